// File: rtl/etc_pkg.sv
// etc_pkg: shared definitions for the ETC lane arbiter.
//   etc_state_e  - scheduler FSM encoding
//   ETC_*        - default widths, overspeed limit, calculator timeout and
//                  barrier hold time used as parameter defaults
package etc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GRANT  = 2'd1,
      ST_WAIT   = 2'd2,
      ST_REPORT = 2'd3
   } etc_state_e;

   localparam int ETC_WIDTH_TIK   = 16;
   localparam int ETC_WIDTH_SPEED = 14;
   localparam int ETC_SPEED_LIMIT = 80;
   localparam int ETC_TIMEOUT     = 1024;
   localparam int ETC_HOLD_CYC    = 5000;

endpackage

// File: rtl/etc_rr_pick.sv
// etc_rr_pick: combinational round-robin picker.
//   req      - per-lane request vector
//   rr_ptr   - lane with highest priority this round
//   win_lane - first requesting lane at or above rr_ptr, wrapping
//   any_req  - at least one lane requesting
module etc_rr_pick #(
   parameter int LANES  = 4,
   parameter int LANE_W = $clog2(LANES)
) (
   input  logic [LANES-1:0]  req,
   input  logic [LANE_W-1:0] rr_ptr,
   output logic [LANE_W-1:0] win_lane,
   output logic              any_req
);

   // Scan offsets from farthest to nearest so the lane closest to rr_ptr
   // is the last (and therefore surviving) assignment.
   always_comb begin
      int j;
      win_lane = '0;
      any_req  = |req;
      for (int k = LANES-1; k >= 0; k--) begin
         j = int'(rr_ptr) + k;
         if (j >= LANES) j = j - LANES;
         if (req[LANE_W'(j)]) win_lane = LANE_W'(j);
      end
   end

endmodule

// File: rtl/etc_lane_arbiter.sv
// etc_lane_arbiter: round-robin scheduler sharing one speed calculator
// between LANES toll lanes.
//   clk, reset_n          - clock, async active-low reset
//   req/tik_in/epass      - per-lane request, tick count, valid E-pass
//   ack                   - one-hot grant pulse (GRANT cycle)
//   calc_start/calc_tik   - calculator start pulse and held operand
//   calc_done/calc_speed  - calculator result handshake
//   res_*                 - one-cycle result strobe with lane/speed/status
//   en_barrier            - per-lane barrier open level, HOLD_CYC long
module etc_lane_arbiter
   import etc_pkg::*;
#(
   parameter int LANES       = 4,
   parameter int LANE_W      = $clog2(LANES),
   parameter int WIDTH_TIK   = ETC_WIDTH_TIK,
   parameter int WIDTH_SPEED = ETC_WIDTH_SPEED,
   parameter logic [WIDTH_SPEED-1:0] SPEED_LIMIT = WIDTH_SPEED'(ETC_SPEED_LIMIT),
   parameter int TIMEOUT     = ETC_TIMEOUT,
   parameter int HOLD_CYC    = ETC_HOLD_CYC
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [LANES-1:0]           req,
   input  logic [LANES*WIDTH_TIK-1:0] tik_in,
   input  logic [LANES-1:0]           epass,
   output logic [LANES-1:0]           ack,
   output logic                       calc_start,
   output logic [WIDTH_TIK-1:0]       calc_tik,
   input  logic                       calc_done,
   input  logic [WIDTH_SPEED-1:0]     calc_speed,
   output logic                       res_valid,
   output logic [LANE_W-1:0]          res_lane,
   output logic [WIDTH_SPEED-1:0]     res_speed,
   output logic                       res_err,
   output logic                       res_overspeed,
   output logic [LANES-1:0]           en_barrier
);

   localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam int HLD_W = $clog2(HOLD_CYC+1);

   etc_state_e                      state, state_nxt;
   logic [LANE_W-1:0]               rr_ptr, win_pick, win_lane;
   logic                            any_req, ep_lat, tmo_hit;
   logic [TMO_W-1:0]                tmo_cnt;
   logic [LANES-1:0]                ack_d;
   logic                            calc_start_d, res_valid_d;
   logic [LANES-1:0][WIDTH_TIK-1:0] tik_v;

   assign tik_v   = tik_in;
   assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT-1));

   etc_rr_pick #(.LANES(LANES), .LANE_W(LANE_W)) u_pick (
      .req      (req),
      .rr_ptr   (rr_ptr),
      .win_lane (win_pick),
      .any_req  (any_req)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (any_req) state_nxt = ST_GRANT;
         ST_GRANT:  state_nxt = ST_WAIT;
         ST_WAIT:   if (calc_done || tmo_hit) state_nxt = ST_REPORT;
         ST_REPORT: state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Strobes are decided one cycle early so they appear registered in the
   // GRANT / REPORT cycles themselves.
   always_comb begin
      ack_d        = '0;
      calc_start_d = 1'b0;
      res_valid_d  = 1'b0;
      if (state == ST_IDLE && any_req) begin
         ack_d[win_pick] = 1'b1;
         calc_start_d    = 1'b1;
      end
      if (state == ST_WAIT && (calc_done || tmo_hit)) res_valid_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ack           <= '0;
         calc_start    <= 1'b0;
         res_valid     <= 1'b0;
         calc_tik      <= '0;
         win_lane      <= '0;
         ep_lat        <= 1'b0;
         rr_ptr        <= '0;
         tmo_cnt       <= '0;
         res_lane      <= '0;
         res_speed     <= '0;
         res_err       <= 1'b0;
         res_overspeed <= 1'b0;
      end else begin
         ack        <= ack_d;
         calc_start <= calc_start_d;
         res_valid  <= res_valid_d;
         case (state)
            ST_IDLE: if (any_req) begin
               win_lane <= win_pick;
               calc_tik <= tik_v[win_pick];
               ep_lat   <= epass[win_pick];
            end
            ST_GRANT: begin
               rr_ptr  <= (win_lane == LANE_W'(LANES-1)) ? '0 : win_lane + 1'b1;
               tmo_cnt <= '0;
            end
            ST_WAIT: begin
               // A result arriving on the expiry cycle still counts.
               if (calc_done) begin
                  res_lane      <= win_lane;
                  res_speed     <= calc_speed;
                  res_err       <= 1'b0;
                  res_overspeed <= (calc_speed > SPEED_LIMIT);
               end else if (tmo_hit) begin
                  res_lane      <= win_lane;
                  res_speed     <= '0;
                  res_err       <= 1'b1;
                  res_overspeed <= 1'b0;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Per-lane barrier hold: loaded in the REPORT cycle of a qualifying pass,
   // so the barrier rises the following cycle and stays up HOLD_CYC cycles.
   for (genvar i = 0; i < LANES; i++) begin : g_hold
      logic [HLD_W-1:0] hold_cnt;
      logic             en_r;
      logic             open_ld;

      assign open_ld = (state == ST_REPORT) && (win_lane == LANE_W'(i)) &&
                       ep_lat && !res_err;

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            hold_cnt <= '0;
            en_r     <= 1'b0;
         end else if (open_ld) begin
            hold_cnt <= HLD_W'(HOLD_CYC);
            en_r     <= 1'b1;
         end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
            en_r     <= (hold_cnt != HLD_W'(1));
         end
      end

      assign en_barrier[i] = en_r;
   end

endmodule

// File: tb/tb_etc_lane_arbiter.sv
// tb_etc_lane_arbiter: transaction-level bench for etc_lane_arbiter.
// A reference model (round-robin pointer, expected result per transaction,
// barrier open windows in absolute cycles) predicts every observed value.
module tb_etc_lane_arbiter;

   localparam int L    = 4;
   localparam int TW   = 16;
   localparam int SW   = 14;
   localparam int LIM  = 80;
   localparam int TMO  = 16;
   localparam int HOLD = 150;

   logic                clk = 1'b0;
   logic                reset_n = 1'b0;
   logic [L-1:0]        req = '0, epass = '0, ack, en_barrier;
   logic [L-1:0][TW-1:0] tik = '0;
   logic                calc_start, calc_done = 1'b0;
   logic                res_valid, res_err, res_overspeed;
   logic [TW-1:0]       calc_tik;
   logic [SW-1:0]       calc_speed = '0, res_speed;
   logic [1:0]          res_lane;

   etc_lane_arbiter #(
      .LANES(L), .LANE_W(2), .WIDTH_TIK(TW), .WIDTH_SPEED(SW),
      .SPEED_LIMIT(14'd80), .TIMEOUT(TMO), .HOLD_CYC(HOLD)
   ) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .tik_in(tik), .epass(epass),
      .ack(ack), .calc_start(calc_start), .calc_tik(calc_tik),
      .calc_done(calc_done), .calc_speed(calc_speed), .res_valid(res_valid),
      .res_lane(res_lane), .res_speed(res_speed), .res_err(res_err),
      .res_overspeed(res_overspeed), .en_barrier(en_barrier)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0, n_err = 0;
   int m_ptr = 0, last_rep = -10;
   int open_at[L], prev_open[L];
   bit chk_en = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h @cyc %0d", tag, got, exp, cyc);
      end
   endtask

   function automatic int pick(input logic [L-1:0] rq, input int p);
      for (int k = 0; k < L; k++)
         if (rq[(p+k)%L]) return (p+k)%L;
      return -1;
   endfunction

   function automatic bit in_win(input int st, input int c);
      return (c >= st) && (c < st + HOLD);
   endfunction

   task automatic clr_model();
      m_ptr = 0;
      for (int i = 0; i < L; i++) begin
         open_at[i]   = -100000;
         prev_open[i] = -100000;
      end
   endtask

   always @(negedge clk)
      if (chk_en)
         for (int i = 0; i < L; i++)
            chk($sformatf("bar%0d", i), 32'(en_barrier[i]),
                32'(in_win(open_at[i], cyc) || in_win(prev_open[i], cyc)));

   // One request/grant/calc/report transaction. Called at a negedge with the
   // DUT idle or in its REPORT cycle. d = calc_done delay after GRANT.
   task automatic run_txn(input logic [L-1:0] rq, input logic [L-1:0] ep,
                          input int d, input logic [SW-1:0] spd, input bit keep);
      int w, g, c0, r_exp;
      bit seen, err;
      logic [TW-1:0] t_w;
      c0 = cyc;
      req = rq; epass = ep;
      w = pick(rq, m_ptr);
      t_w = tik[w];
      seen = 0;
      for (int k = 0; k < 6 && !seen; k++) begin
         @(negedge clk);
         if (ack != '0) seen = 1;
      end
      if (!seen) begin
         chk("ack_timeout", 0, 1);
         req = '0;
         return;
      end
      g = cyc;
      chk("ack", 32'(ack), 32'(1 << w));
      chk("ack_lat", g - c0, (c0 == last_rep) ? 2 : 1);
      chk("start", 32'(calc_start), 1);
      chk("tik", 32'(calc_tik), 32'(t_w));
      m_ptr = (w + 1) % L;
      if (!keep) req = '0;
      err   = (d > TMO);
      r_exp = g + (err ? TMO : d) + 1;
      seen  = 0;
      for (int k = 0; k < TMO + 6 && !seen; k++) begin
         calc_done  = (cyc == g + d);
         calc_speed = spd;
         @(negedge clk);
         if (cyc == g + 1) chk("ack_pulse", {ack, calc_start}, 0);
         if (res_valid) seen = 1;
      end
      calc_done = 1'b0;
      if (!seen) begin
         chk("res_timeout", 0, 1);
         return;
      end
      chk("res_lat", cyc - g, r_exp - g);
      chk("res_lane", 32'(res_lane), 32'(w));
      chk("res_speed", 32'(res_speed), err ? 0 : 32'(spd));
      chk("res_err", 32'(res_err), 32'(err));
      chk("res_ovs", 32'(res_overspeed), 32'(!err && (int'(spd) > LIM)));
      chk("tik_hold", 32'(calc_tik), 32'(t_w));
      last_rep = cyc;
      if (ep[w] && !err) begin
         prev_open[w] = open_at[w];
         open_at[w]   = cyc + 1;
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int cnt, r1;
      bit seen;
      logic [L-1:0] rq, ep;
      clr_model();

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_ctl", {ack, calc_start, res_valid, res_err, res_overspeed, en_barrier}, 0);
      chk("rst_data", {calc_tik, res_speed, res_lane}, 0);
      reset_n = 1'b1;
      chk_en  = 1'b1;
      @(negedge clk);

      // contention: all lanes, instant result -> order 0,1,2,3,0
      for (int i = 0; i < L; i++) tik[i] = 16'(100 + i);
      for (int n = 0; n < 5; n++) run_txn(4'b1111, 4'b0000, 1, 14'(10 + n), n < 4);
      repeat (3) @(negedge clk);

      // single lane with pass, barrier length
      tik[1] = 16'd500;
      run_txn(4'b0010, 4'b0010, 3, 14'd60, 0);
      cnt = 0;
      for (int k = 0; k < HOLD + 10; k++) begin
         @(negedge clk);
         if (en_barrier[1]) cnt++;
      end
      chk("hold_len", cnt, HOLD);

      // timeout, barrier must stay shut
      tik[3] = 16'hbeef;
      run_txn(4'b1000, 4'b1000, 100, 14'd0, 0);
      // result on the expiry cycle wins; one cycle later is a timeout
      run_txn(4'b0001, 4'b0000, TMO, 14'd33, 0);
      run_txn(4'b0001, 4'b0000, TMO + 1, 14'd33, 0);

      // policy and overspeed boundary
      run_txn(4'b0001, 4'b0000, 2, 14'd50, 0);
      run_txn(4'b1000, 4'b1000, 2, 14'd95, 0);
      run_txn(4'b0100, 4'b0000, 1, 14'd80, 0);
      run_txn(4'b0100, 4'b0000, 1, 14'd81, 0);
      run_txn(4'b0010, 4'b0000, 1, 14'h3fff, 0);

      // calc_done outside WAIT is ignored
      repeat (2) @(negedge clk);
      calc_done = 1'b1;
      @(negedge clk);
      calc_done = 1'b0;
      cnt = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (res_valid || calc_start) cnt++;
      end
      chk("stray_done", cnt, 0);

      // retrigger lane 2, second result 100 cycles later
      repeat (HOLD) @(negedge clk);
      tik[2] = 16'd777;
      run_txn(4'b0100, 4'b0100, 1, 14'd40, 0);
      r1 = last_rep;
      while (cyc < r1 + 97) @(negedge clk);
      run_txn(4'b0100, 4'b0100, 1, 14'd41, 0);
      chk("retrig_gap", last_rep - r1, 100);
      cnt = 0;
      for (int k = 0; k < HOLD + 10; k++) begin
         @(negedge clk);
         if (en_barrier[2]) cnt++;
      end
      chk("retrig_hold", cnt, HOLD);

      // randomized traffic
      for (int n = 0; n < 40; n++) begin
         rq = 4'($urandom_range(1, 15));
         ep = 4'($urandom);
         for (int i = 0; i < L; i++) tik[i] = 16'($urandom);
         run_txn(rq, ep, $urandom_range(1, 20),
                 ($urandom_range(0, 3) == 0) ? 14'($urandom) : 14'($urandom_range(60, 100)), 0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // reset while waiting on the calculator
      repeat (HOLD + 5) @(negedge clk);
      tik[0] = 16'd7;
      run_txn(4'b0001, 4'b0001, 2, 14'd30, 0);
      repeat (5) @(negedge clk);
      tik[2] = 16'h1234;
      req = 4'b0100; epass = 4'b0100;
      seen = 0;
      for (int k = 0; k < 6 && !seen; k++) begin
         @(negedge clk);
         if (ack != '0) seen = 1;
      end
      chk("rst_ack", 32'(ack), 32'(4'b0100));
      req = '0;
      repeat (4) @(negedge clk);
      #2 reset_n = 1'b0;
      clr_model();
      #1;
      chk("rstw_ctl", {ack, calc_start, res_valid, res_err, res_overspeed, en_barrier}, 0);
      chk("rstw_data", {calc_tik, res_speed, res_lane}, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      cnt = 0;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk);
         if (res_valid) cnt++;
      end
      chk("rstw_nores", cnt, 0);
      tik[0] = 16'd11; tik[3] = 16'd33;
      run_txn(4'b1001, 4'b0000, 1, 14'd20, 0);

      repeat (3) @(negedge clk);
      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/etc_lane_arbiter.md
Name: etc_lane_arbiter

Overview:
Multi-lane scheduler for the non-stop ETC speed-calculation datapath. Each lane's controller raises a request once it has a tick count between sensors. The block round-robin grants one shared speed calculator and sequences it with a start/done handshake, with timeout. It then returns speed, error and overspeed status to the winning lane and drives that lane's barrier-enable for a fixed hold time.

Parameters:
LANES, 4, number of requesting lanes (2..8)
LANE_W, 2, lane index width, equal to clog2(LANES)
WIDTH_TIK, 16, tick-count width per lane
WIDTH_SPEED, 14, speed result width
SPEED_LIMIT, 14'd80, overspeed threshold, same units as calc_speed
TIMEOUT, 1024, maximum cycles waiting for calc_done
HOLD_CYC, 5000, cycles en_barrier stays high after a pass

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
req  in  LANES  per-lane request; held high until ack
tik_in  in  LANES*WIDTH_TIK  lane i tick count at bits [i*WIDTH_TIK +: WIDTH_TIK]
epass  in  LANES  per-lane valid E-pass; sampled with tik_in
ack  out  LANES  one-cycle grant/accept pulse, one-hot
calc_start  out  1  one-cycle start pulse to the speed calculator
calc_tik  out  WIDTH_TIK  operand to the calculator; stable from start to done
calc_done  in  1  calculator result-valid pulse
calc_speed  in  WIDTH_SPEED  calculator result; valid with calc_done
res_valid  out  1  one-cycle result strobe
res_lane  out  LANE_W  lane index of the result
res_speed  out  WIDTH_SPEED  speed reported; 0 on timeout
res_err  out  1  timeout flag, valid with res_valid
res_overspeed  out  1  res_speed > SPEED_LIMIT, valid with res_valid
en_barrier  out  LANES  per-lane barrier open level

Behaviour:
- All outputs are registered. Reset asserted (async) forces:
  - state IDLE, rr_ptr 0
  - all outputs 0 and all hold counters 0
- Reset mid-operation aborts any calculation silently. No res_valid is issued.
- FSM states: IDLE, GRANT, WAIT, REPORT.
- IDLE:
  - If any req bit is set, pick the winner: the first set bit searching upward from rr_ptr, wrapping modulo LANES.
  - On that edge, latch win_lane, tik_in slice into calc_tik, and epass bit. Go to GRANT.
- GRANT (exactly 1 cycle):
  - ack[win_lane]=1 and calc_start=1.
  - rr_ptr <= win_lane+1, wrapping to 0 past LANES-1.
  - Clear the timeout counter. Go to WAIT.
- WAIT:
  - calc_tik is held.
  - On calc_done, latch calc_speed and go to REPORT with err=0.
  - Otherwise the timeout counter increments each cycle. When it reaches TIMEOUT-1, go to REPORT with err=1 and speed 0.
  - calc_done on the same cycle as expiry: done wins, err=0.
  - calc_done seen outside WAIT is ignored.
- REPORT (exactly 1 cycle): res_valid=1, with res_lane, res_speed, res_err and res_overspeed (0 if err). Go to IDLE.
  - Minimum request-to-result latency: 4 cycles (req seen in IDLE, GRANT, WAIT with calc_done in the first WAIT cycle, REPORT).
- en_barrier[i]:
  - Set high on the cycle after REPORT when lane i won, its latched epass=1 and err=0. The overspeed result does not block opening.
  - Stays high for HOLD_CYC cycles, then falls.
  - A new qualifying result for the same lane reloads the counter to the full HOLD_CYC.
  - Lanes time independently; several may be high together.
- Request rules:
  - req may drop after ack. Dropping req before ack simply removes the lane from arbitration.
  - A req held continuously re-requests after REPORT and is served under round-robin fairness.
  - With all lanes requesting, each lane is served once per LANES grants.
- Widths:
  - Overspeed compare is unsigned at WIDTH_SPEED.
  - The timeout counter is clog2(TIMEOUT) bits.
  - Each hold counter is clog2(HOLD_CYC+1) bits.

Decomposition:
- Shared package etc_pkg:
  - FSM state encoding (IDLE/GRANT/WAIT/REPORT)
  - default WIDTH_TIK/WIDTH_SPEED
  - SPEED_LIMIT, TIMEOUT and HOLD_CYC constants
- One natural sub-module, etc_rr_pick: combinational round-robin priority picker. Inputs: req, rr_ptr. Outputs: win_lane, any_req.
- The hold counters are instantiated per lane inside the top, with no separate module.

Test Plan:
- Single lane: req=4'b0010, tik_in lane1=16'd500, epass=1, calc_done 3 cycles after calc_start with speed 60.
  -> ack[1] pulses, calc_tik=500, res_lane=1, res_speed=60, overspeed=0, err=0.
  -> en_barrier[1] high for exactly HOLD_CYC cycles.
- Contention: req=4'b1111 held, rr_ptr=0, instant calc_done on every grant.
  -> grant order 0,1,2,3,0; ack always one-hot.
- Timeout: calc_done never asserted, TIMEOUT=16.
  -> res_valid exactly 16 cycles after the WAIT entry cycle, res_err=1, res_speed=0, en_barrier stays 0.
- Policy: epass=0 with speed 50 -> no barrier. epass=1 with speed 95 -> res_overspeed=1 and barrier opens.
- Retrigger: two qualifying results for lane 2 spaced 100 cycles apart.
  -> en_barrier[2] falls HOLD_CYC cycles after the second result.
- Reset in WAIT: reset_n pulsed low.
  -> all outputs 0 immediately; no res_valid; next request is arbitrated from rr_ptr=0.
